// File: rtl/hdd_stream_ctrl_if.sv
// Command, read-stream and write-stream handshakes between a requester and hdd_stream_ctrl.
// The requester drives through the master modport; the controller uses the slave modport.
interface hdd_stream_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [63:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;

    logic             rd_valid;
    logic             rd_ready;
    logic [63:0]      rd_data;

    logic             wr_valid;
    logic             wr_ready;
    logic [63:0]      wr_data;

    logic             done;
    logic             busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ready, wr_valid, wr_data,
        input  cmd_ready, rd_valid, rd_data, wr_ready, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ready, wr_valid, wr_data,
        output cmd_ready, rd_valid, rd_data, wr_ready, done, busy
    );
endinterface

// File: rtl/hdd_stream_ctrl.sv
// Turns absolute-address read/write block commands into relative seeks and load/save
// strobes for the HDD, streaming words over valid/ready with a small read-return FIFO.
module hdd_stream_ctrl #(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    hdd_stream_ctrl_if.slave bus,
    output logic [63:0]      hdd_seek,
    output logic             hdd_load,
    output logic             hdd_save,
    output logic [63:0]      hdd_in,
    input  logic [63:0]      hdd_out
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEEK  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [63:0]      pos_q, pos_d;
    logic [63:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [63:0]      mem_d [FIFO_DEPTH];

    logic             fifo_nonempty;
    logic             pop;
    logic             push;
    logic             issue;
    logic             xfer;
    logic [OCC_W-1:0] occ;

    assign fifo_nonempty = (count_q != '0);
    assign bus.rd_valid  = fifo_nonempty;
    assign bus.rd_data   = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign bus.busy      = (state_q != S_IDLE) || fifo_nonempty;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        addr_d     = addr_q;
        write_d    = write_q;
        rem_d      = rem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        issue      = 1'b0;
        xfer       = 1'b0;

        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.done      = 1'b0;
        hdd_seek      = '0;
        hdd_load      = 1'b0;
        hdd_save      = 1'b0;
        hdd_in        = '0;

        // The disk word lands on hdd_out exactly one cycle after its load, so the
        // in-flight flag alone decides the push; a reset clears it and drops that word.
        pop  = fifo_nonempty && bus.rd_ready;
        push = inflight_q;
        if (push) begin
            mem_d[wr_ptr_q] = hdd_out;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        occ     = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);

        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                hdd_seek = addr_q - pos_q;
                pos_d    = addr_q;
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = write_q ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                // Only issue when the word is guaranteed a FIFO slot on arrival.
                issue = (rem_q != '0) && (occ <= OCC_W'(FIFO_DEPTH - 1));
                if (issue) begin
                    hdd_load = 1'b1;
                    hdd_seek = 64'd1;
                    pos_d    = pos_q + 64'd1;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                bus.wr_ready = (rem_q != '0);
                xfer         = bus.wr_valid && bus.wr_ready;
                if (xfer) begin
                    hdd_save = 1'b1;
                    hdd_in   = bus.wr_data;
                    hdd_seek = 64'd1;
                    pos_d    = pos_q + 64'd1;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = issue;

        // The disk is reset alongside this block, so it must see no movement then.
        if (rst) begin
            hdd_seek = '0;
            hdd_load = 1'b0;
            hdd_save = 1'b0;
            hdd_in   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_hdd_stream_ctrl.sv
// Scoreboard bench for hdd_stream_ctrl: a behavioural disk model, a command-level
// reference for positions and memory contents, and a negedge monitor popping expectations.
module tb_hdd_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] hdd_seek;
    logic        hdd_load;
    logic        hdd_save;
    logic [63:0] hdd_in;
    logic [63:0] hdd_out = '0;

    hdd_stream_ctrl_if #(.LEN_W(16)) bus ();

    hdd_stream_ctrl #(.LEN_W(16), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hdd_seek (hdd_seek),
        .hdd_load (hdd_load),
        .hdd_save (hdd_save),
        .hdd_in   (hdd_in),
        .hdd_out  (hdd_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Disk: relative pointer, load data appears the next cycle.
    logic [63:0] disk_ptr = '0;
    logic [63:0] disk_mem [logic [63:0]];

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return a * 64'h9E37_79B9_7F4A_7C15 + 64'h1234;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            disk_ptr <= '0;
        end else begin
            if (hdd_load) hdd_out <= disk_mem.exists(disk_ptr) ? disk_mem[disk_ptr] : init_word(disk_ptr);
            if (hdd_save) disk_mem[disk_ptr] = hdd_in;
            disk_ptr <= disk_ptr + hdd_seek;
        end
    end

    // Reference model state.
    logic [63:0] ref_pos = '0;
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] exp_seek [$];
    logic [63:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    logic [63:0] wq [$];
    int unsigned exp_loads = 0;

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h required no event at %0t", nm, act, $time);
    endtask

    // Monitor state.
    int unsigned cyc = 0;
    int unsigned first_load_cyc = 0;
    int unsigned loads_c = 0;
    int unsigned pops_c = 0;
    bit seek_next = 0;
    bit want_first = 0;
    bit rd_pending = 0;
    bit prev_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (bus.rd_valid && rd_pending) begin
                chk("first_rd_latency", 64'(cyc - first_load_cyc), 64'd2);
                rd_pending = 0;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                pops_c++;
                if (exp_rd.size() == 0) unexpected("rd_extra_word", bus.rd_data);
                else chk("rd_data", bus.rd_data, exp_rd.pop_front());
            end
            if (seek_next) begin
                seek_next = 0;
                if (exp_seek.size() == 0) unexpected("seek_extra", hdd_seek);
                else chk("seek_delta", hdd_seek, exp_seek.pop_front());
                chk("seek_no_strobe", 64'({hdd_load, hdd_save}), 64'd0);
            end else if (hdd_load || hdd_save) begin
                chk("load_save_exclusive", 64'(hdd_load & hdd_save), 64'd0);
                chk("strobe_seek_one", hdd_seek, 64'd1);
                if (hdd_save) begin
                    if (exp_wr.size() == 0) unexpected("save_extra", hdd_in);
                    else chk("save_data", hdd_in, exp_wr.pop_front());
                end
                if (hdd_load) begin
                    loads_c++;
                    if (want_first) begin
                        want_first = 0;
                        rd_pending = 1;
                        first_load_cyc = cyc;
                    end
                    if (exp_loads == 0) unexpected("load_extra", disk_ptr);
                    else exp_loads--;
                    chk("outstanding_le_depth", 64'(loads_c - pops_c <= 2), 64'd1);
                end
            end else begin
                chk("idle_seek_zero", hdd_seek, 64'd0);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                seek_next = 1;
                want_first = 1;
                rd_pending = 0;
                loads_c = 0;
                pops_c = 0;
            end
            if (prev_done) begin
                chk("done_single_cycle", 64'(bus.done), 64'd0);
                chk("idle_after_done", 64'(bus.cmd_ready), 64'd1);
            end
            if (bus.done) begin
                chk("done_rd_all_popped", 64'(exp_rd.size()), 64'd0);
                chk("done_wr_all_saved", 64'(exp_wr.size()), 64'd0);
                chk("done_loads_all_issued", 64'(exp_loads), 64'd0);
                chk("done_busy", 64'(bus.busy), 64'd1);
            end
            prev_done = bus.done;
        end
    end

    task automatic issue_cmd(input bit w, input logic [63:0] a, input int unsigned l, input bit fixed);
        logic [63:0] d;
        bit acc;
        int unsigned t;
        exp_seek.push_back(a - ref_pos);
        ref_pos = a + 64'(l);
        for (int unsigned i = 0; i < l; i++) begin
            if (w) begin
                d = fixed ? 64'hA + 64'(i) : {$urandom, $urandom};
                ref_mem[a + 64'(i)] = d;
                exp_wr.push_back(d);
                wq.push_back(d);
            end else begin
                exp_rd.push_back(ref_rd(a + 64'(i)));
            end
        end
        if (!w) exp_loads += l;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = 16'(l);
        acc = 0;
        t = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accepted", 64'(acc), 64'd1);
    endtask

    task automatic data_phase(input int unsigned stall, input int unsigned rd_pct,
                              input logic [15:0] wmask, input int unsigned wr_pct);
        int unsigned k = 0;
        int unsigned idx = 0;
        bit xfer;
        bit dn = 0;
        while (!dn && k < 400) begin
            bus.rd_ready = (k >= stall) && ($urandom_range(99) < rd_pct);
            if (wmask != '0) bus.wr_valid = (k < 16) && wmask[k[3:0]] && (idx < wq.size());
            else bus.wr_valid = (idx < wq.size()) && ($urandom_range(99) < wr_pct);
            bus.wr_data = (idx < wq.size()) ? wq[idx] : {$urandom, $urandom};
            @(negedge clk);
            xfer = bus.wr_valid && bus.wr_ready;
            dn = bus.done;
            @(posedge clk);
            #1;
            if (xfer) idx++;
            k++;
        end
        chk("done_seen", 64'(dn), 64'd1);
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        wq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        bit got;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.rd_ready  = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_strobes", 64'({hdd_load, hdd_save}), 64'd0);
        chk("rst_hdd_in", hdd_in, 64'd0);
        @(posedge clk);
        #1;

        issue_cmd(1, 64'd5, 3, 1);   data_phase(0, 100, 16'h0000, 100);
        issue_cmd(0, 64'd5, 3, 0);   data_phase(0, 100, 16'h0000, 100);
        issue_cmd(0, 64'd5, 4, 0);   data_phase(5, 100, 16'h0000, 100);
        issue_cmd(1'($urandom_range(1)), 64'd100, 0, 0); data_phase(0, 100, 16'h0000, 100);
        issue_cmd(1, 64'd40, 2, 0);  data_phase(0, 100, 16'h0012, 100);
        issue_cmd(0, 64'd40, 2, 0);  data_phase(0, 100, 16'h0000, 100);
        issue_cmd(1, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0); data_phase(0, 100, 16'h0000, 100);
        issue_cmd(0, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0); data_phase(0, 100, 16'h0000, 100);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(2))
                0:       a = 64'($urandom_range(63));
                1:       a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
                default: a = {$urandom, $urandom};
            endcase
            issue_cmd(1'($urandom_range(1)), a, $urandom_range(6), 0);
            data_phase($urandom_range(4), $urandom_range(100, 30), 16'h0000, $urandom_range(100, 30));
        end

        // Reset with one word queued and one in flight.
        issue_cmd(0, 64'd5, 4, 0);
        bus.rd_ready = 1'b0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.rd_valid;
        end
        chk("rv_before_rst", 64'(got), 64'd1);
        rst = 1'b1;
        exp_seek.delete();
        exp_rd.delete();
        exp_wr.delete();
        exp_loads = 0;
        ref_pos = '0;
        seek_next = 0;
        want_first = 0;
        rd_pending = 0;
        prev_done = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("post_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("post_rst_load", 64'(hdd_load), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_word", 64'(bus.rd_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue_cmd(1, 64'd7, 1, 0); data_phase(0, 100, 16'h0000, 100);
        issue_cmd(0, 64'd7, 1, 0); data_phase(0, 100, 16'h0000, 100);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hdd_stream_ctrl.md
Name: hdd_stream_ctrl

Overview:
- Command-driven controller sitting directly upstream of the 64-bit relative-seek HDD component; it is the only block that drives the disk's seek/load/save/in pins and consumes its out.
- Converts absolute-address block commands (read or write N words) into relative seeks, per-word load/save strobes and auto-advance.
- Streams read data out, and write data in, over valid/ready handshakes.
- Tracks the disk head position internally because the disk only accepts relative seeks.

Parameters:
- LEN_W, 16, width of the command word count.
- FIFO_DEPTH, 2, read-return buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller accepts command (high only in IDLE)
- cmd_write  input  1  1 = write to disk, 0 = read from disk
- cmd_addr  input  64  absolute start word address
- cmd_len  input  LEN_W  word count, 0 allowed
- rd_valid  output  1  read word available
- rd_ready  input  1  consumer takes read word
- rd_data  output  64  read word
- wr_valid  input  1  write word offered
- wr_ready  output  1  controller accepts write word
- wr_data  input  64  write word
- done  output  1  one-cycle pulse when a command fully completes
- busy  output  1  state != IDLE or FIFO non-empty
- hdd_seek  output  64  relative seek to disk, 0 when idle
- hdd_load  output  1  disk load strobe
- hdd_save  output  1  disk save strobe
- hdd_in  output  64  disk write data
- hdd_out  input  64  disk read data, valid the cycle after hdd_load

Behaviour:
- Disk timing contract:
  - On a clk edge with hdd_load, the disk captures mem[pointer] using the pre-edge pointer; the word appears on hdd_out the following cycle.
  - hdd_save writes mem[pre-edge pointer].
  - The pointer updates by hdd_seek on every edge.
- Head position register pos, 64-bit, reset 0. The disk pointer is also 0 at reset release; the system guarantees this.
- Reset values: state IDLE, pos 0, FIFO empty, in-flight flag 0, words-remaining counter 0. All strobes 0, hdd_seek 0, hdd_in 0, rd_data 0, rd_valid 0, wr_ready 0, done 0, cmd_ready 1 (IDLE).
- States: IDLE, SEEK, READ, WRITE, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch write flag, addr and len into rem, then go to SEEK.
- SEEK (exactly 1 cycle, even when delta is 0):
  - hdd_seek = addr - pos, modulo 2^64; pos <= addr.
  - Next state: if rem==0, DONE; else READ or WRITE.
- READ:
  - Issue a load (hdd_load=1, hdd_seek=1, pos+=1, rem-=1) when rem>0 and (FIFO count + in-flight - pop this cycle) <= 1.
  - in-flight <= issue. The word on hdd_out is pushed into the FIFO the cycle after an issue.
  - rd_valid = FIFO non-empty; rd_data = FIFO head; pop on rd_valid & rd_ready.
  - With rd_ready held high, sustained throughput is 1 word/cycle; first rd_valid appears 2 cycles after the first issue.
  - When rem==0 after the last issue, go to DRAIN.
- DRAIN: wait until in-flight==0 and FIFO empty, then DONE.
- WRITE:
  - wr_ready = (rem>0).
  - On wr_valid & wr_ready: hdd_save=1, hdd_in=wr_data, hdd_seek=1, pos+=1, rem-=1.
  - When no transfer occurs, hdd_save=0 and hdd_seek=0.
  - When rem reaches 0, go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. A new command is accepted no earlier than the cycle after done.
- After any command, pos = addr + len, modulo 2^64, with wrap.
- hdd_seek is 0 in every cycle that is neither SEEK nor an issuing or saving cycle.
- hdd_load and hdd_save are never asserted in the same cycle.
- Reset mid-operation:
  - Return to IDLE and flush the FIFO.
  - Any word arriving on hdd_out the next cycle is discarded.
  - pos returns to 0; the disk must be reset in the same cycle.

Test Plan:
- Reset, then write cmd addr=5 len=3 with wr_data 0xA,0xB,0xC presented back-to-back:
  - SEEK cycle shows hdd_seek=5.
  - Three save cycles, each with hdd_seek=1; done pulses; pos=8.
- Read cmd addr=5 len=3 after the prior write, rd_ready=1:
  - SEEK hdd_seek=0xFFFF_FFFF_FFFF_FFFD (-3).
  - rd_data 0xA,0xB,0xC on consecutive cycles; done after the last pop.
- Read len=4 with rd_ready low for 5 cycles, then high:
  - At most 2 loads issued while stalled; no word dropped or duplicated; order preserved.
- Command len=0 at addr=100:
  - One SEEK cycle with hdd_seek=100-pos, then done; no load or save strobes; pos=100.
- Write len=2 with wr_valid gapped (valid on cycles 1 and 4 only):
  - hdd_save/hdd_seek asserted only on those cycles; hdd_seek=0 in gap cycles.
- Assert rst during READ with 1 word in flight and 1 in the FIFO:
  - Next cycle state IDLE, rd_valid=0, hdd_load=0, pos=0, busy=0; no word emitted afterwards.
